// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one slow word memory between instruction fetch (I) and load/store (D)
module unified_mem_arbiter #(
    parameter int LATENCY      = 3,
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_resp_valid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_resp_valid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(LATENCY - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [SW-1:0] d_streak;
    logic          owner_d;
    logic          op_write;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   i_rdata_q;
    logic [31:0]   d_rdata_q;
    logic          grant_d;
    logic          grant_i;
    logic          last_access;

    // D wins unless it has starved a waiting I for MAX_D_STREAK grants in a row
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE && reset) begin
            if (d_req && !(i_req && d_streak == STREAK_MAX)) begin
                grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    assign last_access = (state == ACCESS) && (cnt == LAST_CNT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_d || grant_i) state_next = ACCESS;
            ACCESS:  if (last_access) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            d_streak  <= '0;
            owner_d   <= 1'b0;
            op_write  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (grant_d || grant_i) begin
                owner_d  <= grant_d;
                op_write <= grant_d && d_write;
                addr_q   <= grant_d ? d_addr : i_addr;
                wdata_q  <= (grant_d && d_write) ? d_wdata : '0;
                cnt      <= '0;
            end else if (state == ACCESS && !last_access) begin
                cnt <= cnt + CW'(1);
            end

            if (grant_d) begin
                if (!i_req) begin
                    d_streak <= '0;
                end else if (d_streak != STREAK_MAX) begin
                    d_streak <= d_streak + SW'(1);
                end
            end else if (grant_i) begin
                d_streak <= '0;
            end

            // memory data is captured on the last access cycle while the bus is still driven
            if (last_access) begin
                if (owner_d) begin
                    d_rdata_q <= op_write ? '0 : mem_dout;
                end else begin
                    i_rdata_q <= mem_dout;
                end
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_din   = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (state == ACCESS) begin
            mem_addr  = addr_q;
            mem_din   = op_write ? wdata_q : '0;
            mem_read  = !op_write;
            mem_write = op_write && (cnt == LAST_CNT);
        end
    end

    assign i_ready      = grant_i;
    assign d_ready      = grant_d;
    assign i_resp_valid = (state == RESP) && !owner_d;
    assign d_resp_valid = (state == RESP) && owner_d;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter at LATENCY 3 and LATENCY 1
module tb_unified_mem_arbiter;
    localparam int LAT_A = 3;

    logic clk;
    logic reset;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 0;

    logic        a_i_req, a_i_ready, a_i_resp_valid;
    logic [31:0] a_i_addr, a_i_rdata;
    logic        a_d_req, a_d_write, a_d_ready, a_d_resp_valid;
    logic [31:0] a_d_addr, a_d_wdata, a_d_rdata;
    logic [31:0] a_mem_addr, a_mem_din, a_mem_dout;
    logic        a_mem_read, a_mem_write;

    logic        b_i_req, b_i_ready, b_i_resp_valid;
    logic [31:0] b_i_addr, b_i_rdata;
    logic        b_d_req, b_d_write, b_d_ready, b_d_resp_valid;
    logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_mem_addr, b_mem_din, b_mem_dout;
    logic        b_mem_read, b_mem_write;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] shadow [0:255];
    bit          pl_en = 0;
    bit          pl_b  = 0;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    typedef struct {
        bit          side_d;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mon_got;

    unified_mem_arbiter #(.LATENCY(LAT_A), .MAX_D_STREAK(4)) dut_a (
        .clk(clk), .reset(reset),
        .i_req(a_i_req), .i_addr(a_i_addr), .i_ready(a_i_ready),
        .i_resp_valid(a_i_resp_valid), .i_rdata(a_i_rdata),
        .d_req(a_d_req), .d_write(a_d_write), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_ready(a_d_ready), .d_resp_valid(a_d_resp_valid), .d_rdata(a_d_rdata),
        .mem_addr(a_mem_addr), .mem_din(a_mem_din), .mem_read(a_mem_read),
        .mem_write(a_mem_write), .mem_dout(a_mem_dout)
    );

    unified_mem_arbiter #(.LATENCY(1), .MAX_D_STREAK(2)) dut_b (
        .clk(clk), .reset(reset),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_ready(b_i_ready),
        .i_resp_valid(b_i_resp_valid), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_write(b_d_write), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ready(b_d_ready), .d_resp_valid(b_d_resp_valid), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_read(b_mem_read),
        .mem_write(b_mem_write), .mem_dout(b_mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign a_mem_dout = mem_a[a_mem_addr[9:2]];
    assign b_mem_dout = mem_b[b_mem_addr[9:2]];

    always @(posedge clk) begin
        if (pl_en) begin
            if (pl_b) mem_b[pl_idx] <= pl_data;
            else      mem_a[pl_idx] <= pl_data;
        end
        if (a_mem_write) mem_a[a_mem_addr[9:2]] <= a_mem_din;
        if (b_mem_write) mem_b[b_mem_addr[9:2]] <= b_mem_din;
    end

    // scoreboard for instance A: push on grant, pop on response
    always @(negedge clk) begin
        if (pl_en && !pl_b) shadow[pl_idx] = pl_data;
        if (mon_en) begin
            if (a_d_ready) begin
                mon_e.side_d = 1'b1;
                mon_e.data   = a_d_write ? 32'h0 : shadow[a_d_addr[9:2]];
                mon_e.due    = cyc + LAT_A + 1;
                if (a_d_write) shadow[a_d_addr[9:2]] = a_d_wdata;
                sb.push_back(mon_e);
            end else if (a_i_ready) begin
                mon_e.side_d = 1'b0;
                mon_e.data   = shadow[a_i_addr[9:2]];
                mon_e.due    = cyc + LAT_A + 1;
                sb.push_back(mon_e);
            end
            if (a_i_resp_valid || a_d_resp_valid) begin
                checks++;
                mon_got = a_d_resp_valid ? a_d_rdata : a_i_rdata;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_resp cyc=%0d i_rv=%b d_rv=%b", cyc, a_i_resp_valid, a_d_resp_valid);
                end else begin
                    mon_e = sb.pop_front();
                    if ({a_d_resp_valid, a_i_resp_valid} !== (mon_e.side_d ? 2'b10 : 2'b01) ||
                        mon_got !== mon_e.data || cyc != mon_e.due) begin
                        failures++;
                        $display("FAIL sb_resp got d_rv=%b i_rv=%b data=%h cyc=%0d want side_d=%0b data=%h cyc=%0d",
                                 a_d_resp_valid, a_i_resp_valid, mon_got, cyc, mon_e.side_d, mon_e.data, mon_e.due);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic preload(input bit to_b, input logic [7:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        pl_en = 1; pl_b = to_b; pl_idx = idx; pl_data = data;
        @(posedge clk); #1;
        pl_en = 0;
    endtask

    task automatic issue_i(input logic [31:0] a, output int t, output int w);
        t = -1; w = 0;
        @(posedge clk); #1;
        a_i_req = 1; a_i_addr = a;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_i_ready) begin t = cyc; w = k; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        a_i_req = 0;
        checks++;
        if (t < 0) begin failures++; $display("FAIL i_grant_timeout got=no_ready want=ready"); end
    endtask

    task automatic issue_d(input bit wr, input logic [31:0] a, input logic [31:0] wd, output int t);
        t = -1;
        @(posedge clk); #1;
        a_d_req = 1; a_d_write = wr; a_d_addr = a; a_d_wdata = wd;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_d_ready) begin t = cyc; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        a_d_req = 0;
        checks++;
        if (t < 0) begin failures++; $display("FAIL d_grant_timeout got=no_ready want=ready"); end
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_i_ready, a_d_ready, a_i_resp_valid, a_d_resp_valid, a_mem_read, a_mem_write} !== 6'b0) begin
            failures++; $display("FAIL reset_a_flags got=%b want=000000",
                {a_i_ready, a_d_ready, a_i_resp_valid, a_d_resp_valid, a_mem_read, a_mem_write});
        end
        checks++;
        if ({a_i_rdata, a_d_rdata, a_mem_addr, a_mem_din} !== 128'h0) begin
            failures++; $display("FAIL reset_a_data got=%h %h %h %h want=0", a_i_rdata, a_d_rdata, a_mem_addr, a_mem_din);
        end
        checks++;
        if ({b_i_ready, b_d_ready, b_i_resp_valid, b_d_resp_valid, b_mem_read, b_mem_write, b_i_rdata, b_d_rdata} !== 70'h0) begin
            failures++; $display("FAIL reset_b got=%b want=0", {b_i_ready, b_d_ready, b_i_resp_valid, b_d_resp_valid});
        end
        @(posedge clk); #1;
        reset = 1;
        mon_en = 1;
    endtask

    task automatic test_fetch();
        int t, w;
        preload(0, 8'd4, 32'h0011_2233);
        issue_i(32'h0000_0010, t, w);
        checks++;
        if (w != 0) begin failures++; $display("FAIL fetch_grant_wait got=%0d want=0", w); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (a_mem_read !== (k <= 3) || a_mem_addr !== ((k <= 3) ? 32'h10 : 32'h0) ||
                a_i_resp_valid !== (k == 4) || a_mem_write !== 1'b0) begin
                failures++;
                $display("FAIL fetch_timing T+%0d got rd=%b addr=%h rv=%b wr=%b want rd=%b rv=%b wr=0",
                         k, a_mem_read, a_mem_addr, a_i_resp_valid, a_mem_write, (k <= 3), (k == 4));
            end
        end
        checks++;
        if (a_i_rdata !== 32'h0011_2233) begin
            failures++; $display("FAIL fetch_rdata_held got=%h want=00112233", a_i_rdata);
        end
    endtask

    task automatic test_store_load();
        int t, wr_cnt;
        wr_cnt = 0;
        issue_d(1, 32'h40, 32'hDEAD_BEEF, t);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (a_mem_write) wr_cnt++;
            checks++;
            if (a_mem_write !== (k == 3) || a_mem_din !== ((k <= 3) ? 32'hDEAD_BEEF : 32'h0) ||
                a_mem_read !== 1'b0 || a_d_resp_valid !== (k == 4)) begin
                failures++;
                $display("FAIL store_timing T+%0d got wr=%b din=%h rd=%b rv=%b want wr=%b rv=%b",
                         k, a_mem_write, a_mem_din, a_mem_read, a_d_resp_valid, (k == 3), (k == 4));
            end
        end
        checks++;
        if (wr_cnt != 1) begin failures++; $display("FAIL store_write_pulses got=%0d want=1", wr_cnt); end
        checks++;
        if (a_d_rdata !== 32'h0) begin failures++; $display("FAIL store_rdata got=%h want=0", a_d_rdata); end
        issue_d(0, 32'h40, 32'h0, t);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) begin
                checks++;
                if (a_d_resp_valid !== 1'b1 || a_d_rdata !== 32'hDEAD_BEEF) begin
                    failures++; $display("FAIL load_resp got rv=%b data=%h want rv=1 data=deadbeef", a_d_resp_valid, a_d_rdata);
                end
            end
        end
        checks++;
        if (a_d_resp_valid !== 1'b0 || a_d_rdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL load_rdata_held got rv=%b data=%h want rv=0 data=deadbeef", a_d_resp_valid, a_d_rdata);
        end
        checks++;
        if (mem_a[16] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_mem_word got=%h want=deadbeef", mem_a[16]); end
        checks++;
        if (a_i_rdata !== 32'h0011_2233) begin failures++; $display("FAIL i_rdata_kept got=%h want=00112233", a_i_rdata); end
    endtask

    task automatic test_contention();
        int n, last;
        preload(0, 8'd64, 32'hA5A5_0100);
        preload(0, 8'd128, 32'h5A5A_0200);
        @(posedge clk); #1;
        a_i_req = 1; a_i_addr = 32'h100;
        a_d_req = 1; a_d_write = 0; a_d_addr = 32'h200;
        n = 0; last = -1;
        for (int k = 0; k < 80 && n < 10; k++) begin
            @(negedge clk);
            if (a_i_ready || a_d_ready) begin
                checks++;
                if ({a_d_ready, a_i_ready} !== ((n % 5 != 4) ? 2'b10 : 2'b01)) begin
                    failures++; $display("FAIL grant_order n=%0d got d=%b i=%b want d=%b", n, a_d_ready, a_i_ready, (n % 5 != 4));
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last != 5) begin failures++; $display("FAIL grant_spacing n=%0d got=%0d want=5", n, cyc - last); end
                end
                last = cyc; n++;
            end
            if (n < 10) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        a_i_req = 0; a_d_req = 0;
        checks++;
        if (n != 10) begin failures++; $display("FAIL contention_grants got=%0d want=10", n); end
        repeat (6) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL contention_drain got=%0d want=0", sb.size()); end
    endtask

    task automatic test_i_only();
        int n, last, bad_d;
        n = 0; last = -1; bad_d = 0;
        @(posedge clk); #1;
        a_i_req = 1; a_i_addr = 32'h100;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (a_d_ready || a_d_resp_valid) bad_d++;
            if (a_i_ready) begin
                if (n > 0) begin
                    checks++;
                    if (cyc - last != 5) begin failures++; $display("FAIL i_only_spacing got=%0d want=5", cyc - last); end
                end
                last = cyc; n++;
            end
            @(posedge clk); #1;
        end
        a_i_req = 0;
        checks++;
        if (n != 6) begin failures++; $display("FAIL i_only_grants got=%0d want=6", n); end
        checks++;
        if (bad_d != 0) begin failures++; $display("FAIL i_only_d_activity got=%0d want=0", bad_d); end
        repeat (6) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL i_only_drain got=%0d want=0", sb.size()); end
    endtask

    task automatic test_reset_abort();
        int t, bad;
        bad = 0;
        preload(0, 8'd32, 32'h1234_5678);
        mon_en = 0;
        issue_d(1, 32'h80, 32'hCAFE_F00D, t);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        checks++;
        if (a_mem_write !== 1'b0 || a_mem_din !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL abort_second_access got wr=%b din=%h want wr=0 din=cafef00d", a_mem_write, a_mem_din);
        end
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        checks++;
        if ({a_i_ready, a_d_ready, a_i_resp_valid, a_d_resp_valid, a_mem_read, a_mem_write} !== 6'b0 ||
            {a_i_rdata, a_d_rdata, a_mem_addr, a_mem_din} !== 128'h0) begin
            failures++; $display("FAIL abort_outputs got flags=%b irdata=%h drdata=%h addr=%h want=0",
                {a_i_ready, a_d_ready, a_i_resp_valid, a_d_resp_valid, a_mem_read, a_mem_write}, a_i_rdata, a_d_rdata, a_mem_addr);
        end
        repeat (6) begin
            @(negedge clk);
            if (a_mem_write || a_d_resp_valid || a_i_resp_valid) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL abort_activity got=%0d want=0", bad); end
        checks++;
        if (mem_a[32] !== 32'h1234_5678) begin failures++; $display("FAIL abort_mem_word got=%h want=12345678", mem_a[32]); end
        mon_en = 1;
        issue_d(0, 32'h80, 32'h0, t);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) begin
                checks++;
                if (a_d_resp_valid !== 1'b1 || a_d_rdata !== 32'h1234_5678) begin
                    failures++; $display("FAIL abort_next_load got rv=%b data=%h want rv=1 data=12345678", a_d_resp_valid, a_d_rdata);
                end
            end
        end
    endtask

    task automatic test_latency1();
        int n, last;
        preload(1, 8'd8, 32'hB0B0_0020);
        @(posedge clk); #1;
        b_i_req = 1; b_i_addr = 32'h20;
        @(negedge clk);
        checks++;
        if (b_i_ready !== 1'b1) begin failures++; $display("FAIL lat1_i_ready got=%b want=1", b_i_ready); end
        @(posedge clk); #1;
        b_i_req = 0;
        @(negedge clk);
        checks++;
        if (b_mem_read !== 1'b1 || b_mem_addr !== 32'h20 || b_i_resp_valid !== 1'b0) begin
            failures++; $display("FAIL lat1_fetch_access got rd=%b addr=%h rv=%b want rd=1 addr=20 rv=0", b_mem_read, b_mem_addr, b_i_resp_valid);
        end
        @(negedge clk);
        checks++;
        if (b_i_resp_valid !== 1'b1 || b_i_rdata !== 32'hB0B0_0020 || b_mem_read !== 1'b0) begin
            failures++; $display("FAIL lat1_fetch_resp got rv=%b data=%h rd=%b want rv=1 data=b0b00020 rd=0", b_i_resp_valid, b_i_rdata, b_mem_read);
        end
        @(posedge clk); #1;
        b_d_req = 1; b_d_write = 1; b_d_addr = 32'h24; b_d_wdata = 32'h7777_1234;
        @(negedge clk);
        checks++;
        if (b_d_ready !== 1'b1) begin failures++; $display("FAIL lat1_d_ready got=%b want=1", b_d_ready); end
        @(posedge clk); #1;
        b_d_req = 0;
        @(negedge clk);
        checks++;
        if (b_mem_write !== 1'b1 || b_mem_din !== 32'h7777_1234 || b_mem_addr !== 32'h24) begin
            failures++; $display("FAIL lat1_store_access got wr=%b din=%h addr=%h want wr=1 din=77771234 addr=24", b_mem_write, b_mem_din, b_mem_addr);
        end
        @(negedge clk);
        checks++;
        if (b_d_resp_valid !== 1'b1 || b_d_rdata !== 32'h0 || b_mem_write !== 1'b0) begin
            failures++; $display("FAIL lat1_store_resp got rv=%b data=%h wr=%b want rv=1 data=0 wr=0", b_d_resp_valid, b_d_rdata, b_mem_write);
        end
        checks++;
        if (mem_b[9] !== 32'h7777_1234) begin failures++; $display("FAIL lat1_mem_word got=%h want=77771234", mem_b[9]); end
        @(posedge clk); #1;
        b_i_req = 1; b_d_req = 1; b_d_write = 0;
        n = 0; last = -1;
        for (int k = 0; k < 40 && n < 6; k++) begin
            @(negedge clk);
            if (b_i_ready || b_d_ready) begin
                checks++;
                if ({b_d_ready, b_i_ready} !== ((n % 3 != 2) ? 2'b10 : 2'b01) || (n > 0 && cyc - last != 3)) begin
                    failures++; $display("FAIL lat1_grant n=%0d got d=%b i=%b gap=%0d want d=%b gap=3", n, b_d_ready, b_i_ready, cyc - last, (n % 3 != 2));
                end
                last = cyc; n++;
            end
            if (n < 6) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        b_i_req = 0; b_d_req = 0;
        checks++;
        if (n != 6) begin failures++; $display("FAIL lat1_grants got=%0d want=6", n); end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset = 0;
        a_i_req = 0; a_i_addr = '0; a_d_req = 0; a_d_write = 0; a_d_addr = '0; a_d_wdata = '0;
        b_i_req = 0; b_i_addr = '0; b_d_req = 0; b_d_write = 0; b_d_addr = '0; b_d_wdata = '0;
        pl_idx = '0; pl_data = '0;
        test_reset();
        test_fetch();
        test_store_load();
        test_contention();
        test_i_only();
        test_reset_abort();
        test_latency1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
